// File: rtl/clock_mode_ctrl.sv
// Mode sequencer (CLOCK/STOPWATCH/ALARM) and stopwatch control FSM with a registered display mux.
// Define CLOCK_MODE_CTRL_LAP_EN to build in lap-freeze support; without it btn_lap is ignored.
module clock_mode_ctrl #(
  parameter int unsigned IDLE_TIMEOUT = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  input  logic [15:0] clk_digits,
  input  logic [15:0] alarm_digits,
  input  logic [15:0] sw_digits,
  output logic [1:0]  mode,
  output logic        sw_mode,
  output logic        sw_run,
  output logic        sw_clear,
  output logic [15:0] disp_digits,
  output logic        disp_blink,
  output logic        lap_active
);

  localparam logic [1:0] MODE_CLOCK  = 2'd0;
  localparam logic [1:0] MODE_SW     = 2'd1;
  localparam logic [1:0] MODE_ALARM  = 2'd2;
  localparam logic [7:0] TIMEOUT_CNT = 8'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2
  } sw_state_e;

  logic        mode_prev_q, mode_prev_d;
  logic        start_prev_q, start_prev_d;
  logic        clear_prev_q, clear_prev_d;
  logic [1:0]  mode_q, mode_d;
  sw_state_e   state_q, state_d;
  logic [7:0]  idle_cnt_q, idle_cnt_d;
  logic        sw_mode_q, sw_mode_d;
  logic        sw_run_q, sw_run_d;
  logic        sw_clear_q, sw_clear_d;
  logic [15:0] disp_q, disp_d;
  logic        blink_q, blink_d;

  logic mode_edge, start_edge, clear_edge, lap_edge_any;
  logic clr_ok, start_ok, timeout;

`ifdef CLOCK_MODE_CTRL_LAP_EN
  logic        lap_prev_q, lap_prev_d;
  logic        lap_active_q, lap_active_d;
  logic [15:0] lap_q, lap_d;
  logic        lap_edge, lap_ok;
`else
  logic        unused_lap;
  assign unused_lap = btn_lap;
`endif

  always_comb begin
    mode_prev_d  = btn_mode;
    start_prev_d = btn_start;
    clear_prev_d = btn_clear;
    mode_edge    = btn_mode & ~mode_prev_q;
    start_edge   = btn_start & ~start_prev_q;
    clear_edge   = btn_clear & ~clear_prev_q;
`ifdef CLOCK_MODE_CTRL_LAP_EN
    lap_prev_d   = btn_lap;
    lap_edge     = btn_lap & ~lap_prev_q;
    lap_edge_any = lap_edge;
`else
    lap_edge_any = 1'b0;
`endif

    // Priority clear > start > lap among edges that would actually take effect.
    clr_ok   = (mode_q == MODE_SW) && clear_edge &&
               ((state_q == SW_IDLE) || (state_q == SW_PAUSE));
    start_ok = (mode_q == MODE_SW) && start_edge && !clr_ok;

    timeout = (mode_q == MODE_ALARM) && tick_1hz &&
              !(mode_edge || start_edge || clear_edge || lap_edge_any) &&
              ((idle_cnt_q + 8'd1) == TIMEOUT_CNT);

    mode_d = mode_q;
    case (mode_q)
      MODE_CLOCK: if (mode_edge) mode_d = MODE_SW;
      MODE_SW:    if (mode_edge) mode_d = MODE_ALARM;
      MODE_ALARM: if (mode_edge || timeout) mode_d = MODE_CLOCK;
      default:    mode_d = MODE_CLOCK;
    endcase

    // Counter idles at zero outside ALARM, so entering ALARM always starts a fresh count.
    idle_cnt_d = idle_cnt_q;
    if ((mode_q != MODE_ALARM) || mode_edge || start_edge || clear_edge ||
        lap_edge_any || timeout) begin
      idle_cnt_d = 8'd0;
    end else if (tick_1hz) begin
      idle_cnt_d = idle_cnt_q + 8'd1;
    end

    state_d = state_q;
    case (state_q)
      SW_IDLE:  if (start_ok) state_d = SW_RUN;
      SW_RUN:   if (start_ok) state_d = SW_PAUSE;
      SW_PAUSE: begin
        if (clr_ok)        state_d = SW_IDLE;
        else if (start_ok) state_d = SW_RUN;
      end
      default:  state_d = SW_IDLE;
    endcase

`ifdef CLOCK_MODE_CTRL_LAP_EN
    lap_ok       = lap_edge && (state_q == SW_RUN) && !clr_ok && !start_ok;
    lap_active_d = lap_active_q;
    lap_d        = lap_q;
    if (clr_ok) begin
      lap_active_d = 1'b0;
    end else if (lap_ok) begin
      if (!lap_active_q) begin
        lap_active_d = 1'b1;
        lap_d        = sw_digits;
      end else begin
        lap_active_d = 1'b0;
      end
    end
`endif

    sw_run_d   = (state_d == SW_RUN);
    sw_clear_d = clr_ok;
    // Hold the datapath enabled through the clear pulse and one cycle after it.
    sw_mode_d  = (mode_d == MODE_SW) || (state_d != SW_IDLE) || clr_ok || sw_clear_q;

    case (mode_q)
      MODE_ALARM: disp_d = alarm_digits;
      MODE_SW: begin
`ifdef CLOCK_MODE_CTRL_LAP_EN
        disp_d = lap_active_q ? lap_q : sw_digits;
`else
        disp_d = sw_digits;
`endif
      end
      default:    disp_d = clk_digits;
    endcase

    if ((mode_q == MODE_SW) && (state_q == SW_PAUSE)) begin
      blink_d = tick_1hz ? ~blink_q : blink_q;
    end else begin
      blink_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_prev_q  <= 1'b1;
      start_prev_q <= 1'b1;
      clear_prev_q <= 1'b1;
      mode_q       <= MODE_CLOCK;
      state_q      <= SW_IDLE;
      idle_cnt_q   <= 8'd0;
      sw_mode_q    <= 1'b0;
      sw_run_q     <= 1'b0;
      sw_clear_q   <= 1'b0;
      disp_q       <= 16'h0000;
      blink_q      <= 1'b0;
`ifdef CLOCK_MODE_CTRL_LAP_EN
      lap_prev_q   <= 1'b1;
      lap_active_q <= 1'b0;
      lap_q        <= 16'h0000;
`endif
    end else begin
      mode_prev_q  <= mode_prev_d;
      start_prev_q <= start_prev_d;
      clear_prev_q <= clear_prev_d;
      mode_q       <= mode_d;
      state_q      <= state_d;
      idle_cnt_q   <= idle_cnt_d;
      sw_mode_q    <= sw_mode_d;
      sw_run_q     <= sw_run_d;
      sw_clear_q   <= sw_clear_d;
      disp_q       <= disp_d;
      blink_q      <= blink_d;
`ifdef CLOCK_MODE_CTRL_LAP_EN
      lap_prev_q   <= lap_prev_d;
      lap_active_q <= lap_active_d;
      lap_q        <= lap_d;
`endif
    end
  end

  assign mode        = mode_q;
  assign sw_mode     = sw_mode_q;
  assign sw_run      = sw_run_q;
  assign sw_clear    = sw_clear_q;
  assign disp_digits = disp_q;
  assign disp_blink  = blink_q;
`ifdef CLOCK_MODE_CTRL_LAP_EN
  assign lap_active  = lap_active_q;
`else
  assign lap_active  = 1'b0;
`endif

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl: a per-cycle vector table plus hand-written timeout, lap and reset sequences.
module tb_clock_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick_1hz, btn_mode, btn_start, btn_clear, btn_lap;
  logic [15:0] clk_digits, alarm_digits, sw_digits;
  logic [1:0]  mode;
  logic        sw_mode, sw_run, sw_clear, disp_blink, lap_active;
  logic [15:0] disp_digits;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef CLOCK_MODE_CTRL_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  typedef struct {
    logic [3:0]  in;    // {tick, btn_mode, btn_start, btn_clear}
    logic [1:0]  mode;
    logic [3:0]  outs;  // {sw_mode, sw_run, sw_clear, disp_blink}
    logic [15:0] disp;
  } vec_t;

  vec_t vecs[33];

  always #5 clk = ~clk;

  clock_mode_ctrl #(.IDLE_TIMEOUT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .btn_mode     (btn_mode),
    .btn_start    (btn_start),
    .btn_clear    (btn_clear),
    .btn_lap      (btn_lap),
    .clk_digits   (clk_digits),
    .alarm_digits (alarm_digits),
    .sw_digits    (sw_digits),
    .mode         (mode),
    .sw_mode      (sw_mode),
    .sw_run       (sw_run),
    .sw_clear     (sw_clear),
    .disp_digits  (disp_digits),
    .disp_blink   (disp_blink),
    .lap_active   (lap_active)
  );

  function automatic vec_t mk(input logic [3:0] in, input logic [1:0] m,
                              input logic [3:0] o, input logic [15:0] d);
    vec_t v;
    v.in = in; v.mode = m; v.outs = o; v.disp = d;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic t, input logic bm, input logic bs, input logic bc, input logic bl);
    tick_1hz = t; btn_mode = bm; btn_start = bs; btn_clear = bc; btn_lap = bl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_mode"},  16'(mode),        16'd0);
    check({tag, "_swm"},   16'(sw_mode),     16'd0);
    check({tag, "_run"},   16'(sw_run),      16'd0);
    check({tag, "_clr"},   16'(sw_clear),    16'd0);
    check({tag, "_blink"}, 16'(disp_blink),  16'd0);
    check({tag, "_disp"},  disp_digits,      16'h0000);
    check({tag, "_lap"},   16'(lap_active),  16'd0);
  endtask

  initial begin
    // CLOCK -> STOPWATCH -> ALARM -> CLOCK with one-cycle display latency.
    vecs[0]  = mk(4'b0000, 2'd0, 4'b0000, 16'h1234);
    vecs[1]  = mk(4'b0100, 2'd1, 4'b1000, 16'h1234);
    vecs[2]  = mk(4'b0000, 2'd1, 4'b1000, 16'h0005);
    vecs[3]  = mk(4'b0100, 2'd2, 4'b0000, 16'h0005);
    vecs[4]  = mk(4'b0000, 2'd2, 4'b0000, 16'h0630);
    vecs[5]  = mk(4'b0100, 2'd0, 4'b0000, 16'h0630);
    vecs[6]  = mk(4'b0000, 2'd0, 4'b0000, 16'h1234);
    // Start, then keep running in the background through ALARM and CLOCK.
    vecs[7]  = mk(4'b0100, 2'd1, 4'b1000, 16'h1234);
    vecs[8]  = mk(4'b0010, 2'd1, 4'b1100, 16'h0005);
    vecs[9]  = mk(4'b0000, 2'd1, 4'b1100, 16'h0005);
    vecs[10] = mk(4'b0100, 2'd2, 4'b1100, 16'h0005);
    vecs[11] = mk(4'b0000, 2'd2, 4'b1100, 16'h0630);
    vecs[12] = mk(4'b0100, 2'd0, 4'b1100, 16'h0630);
    vecs[13] = mk(4'b0000, 2'd0, 4'b1100, 16'h1234);
    vecs[14] = mk(4'b0100, 2'd1, 4'b1100, 16'h1234);
    // Pause, blink toggles on ticks 1,0,1,0.
    vecs[15] = mk(4'b0010, 2'd1, 4'b1000, 16'h0005);
    vecs[16] = mk(4'b1000, 2'd1, 4'b1001, 16'h0005);
    vecs[17] = mk(4'b0000, 2'd1, 4'b1001, 16'h0005);
    vecs[18] = mk(4'b1000, 2'd1, 4'b1000, 16'h0005);
    vecs[19] = mk(4'b1000, 2'd1, 4'b1001, 16'h0005);
    vecs[20] = mk(4'b1000, 2'd1, 4'b1000, 16'h0005);
    // Clear and start together in PAUSE: clear wins.
    vecs[21] = mk(4'b0011, 2'd1, 4'b1010, 16'h0005);
    vecs[22] = mk(4'b0000, 2'd1, 4'b1000, 16'h0005);
    // Clear ignored in RUN; clear from PAUSE together with leaving STOPWATCH.
    vecs[23] = mk(4'b0010, 2'd1, 4'b1100, 16'h0005);
    vecs[24] = mk(4'b0001, 2'd1, 4'b1100, 16'h0005);
    vecs[25] = mk(4'b0010, 2'd1, 4'b1000, 16'h0005);
    vecs[26] = mk(4'b0101, 2'd2, 4'b1010, 16'h0005);
    vecs[27] = mk(4'b0000, 2'd2, 4'b1000, 16'h0630);
    vecs[28] = mk(4'b0000, 2'd2, 4'b0000, 16'h0630);
    vecs[29] = mk(4'b0100, 2'd0, 4'b0000, 16'h0630);
    vecs[30] = mk(4'b0000, 2'd0, 4'b0000, 16'h1234);
    // Start ignored outside STOPWATCH.
    vecs[31] = mk(4'b0010, 2'd0, 4'b0000, 16'h1234);
    vecs[32] = mk(4'b1000, 2'd0, 4'b0000, 16'h1234);

    clk_digits = 16'h1234; alarm_digits = 16'h0630; sw_digits = 16'h0005;
    rst = 1'b1;
    tick_1hz = 1'b0; btn_mode = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;

    // Reset held with btn_mode high, then released: no mode step.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_reset_state("reset0");
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rel0_mode", 16'(mode), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rel0_mode_b", 16'(mode), 16'd0);

    for (int i = 0; i < 33; i++) begin
      cyc(vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0], 1'b0);
      check($sformatf("v%0d_mode", i),  16'(mode),       16'(vecs[i].mode));
      check($sformatf("v%0d_swm", i),   16'(sw_mode),    16'(vecs[i].outs[3]));
      check($sformatf("v%0d_run", i),   16'(sw_run),     16'(vecs[i].outs[2]));
      check($sformatf("v%0d_clr", i),   16'(sw_clear),   16'(vecs[i].outs[1]));
      check($sformatf("v%0d_blink", i), 16'(disp_blink), 16'(vecs[i].outs[0]));
      check($sformatf("v%0d_disp", i),  disp_digits,     vecs[i].disp);
    end

    // ALARM idle timeout of 3 ticks.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_entry", 16'(mode), 16'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_tick1", 16'(mode), 16'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_tick2", 16'(mode), 16'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to_tick3", 16'(mode), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Button on tick 2 restarts the count: return on tick 5.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to2_entry", 16'(mode), 16'd2);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("to2_tick2", 16'(mode), 16'd2);
    check("to2_run", 16'(sw_run), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to2_tick4", 16'(mode), 16'd2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to2_tick5", 16'(mode), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Lap freeze while running (ignored when lap support is not built in).
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sw_digits = 16'h0123;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("lap_run", 16'(sw_run), 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_set", 16'(lap_active), LAP ? 16'd1 : 16'd0);
    sw_digits = 16'h0124;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_hold_disp", disp_digits, LAP ? 16'h0123 : 16'h0124);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("lap_release", 16'(lap_active), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lap_live_disp", disp_digits, 16'h0124);

    // Reset mid-run, arriving together with a fresh btn_mode press.
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check_reset_state("reset1");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rel1_mode", 16'(mode), 16'd0);
    check("rel1_run", 16'(sw_run), 16'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rel1_mode_b", 16'(mode), 16'd0);
    check("rel1_swm", 16'(sw_mode), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
